// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the two-core round-robin bus arbiter.
// Holds the FSM state encoding, the owner encoding and the default hold limit.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN1 = 2'd1,
    OWN2 = 2'd2
  } arb_state_e;

  localparam logic OWNER_CORE1 = 1'b0;
  localparam logic OWNER_CORE2 = 1'b1;

  localparam int MAX_HOLD_DEFAULT = 16;
  localparam int HOLD_W           = 8;

  function automatic arb_state_e own_state(input logic who);
    return (who == OWNER_CORE1) ? OWN1 : OWN2;
  endfunction

endpackage

// File: rtl/arb_hold_timer.sv
// Saturating count of contended ownership cycles; cleared when a core takes the bus.
// expired is combinational and marks the edge on which the count reaches MAX_HOLD.
module arb_hold_timer
  import bus_arb_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic cnt_en,
  output logic expired
);

  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] count_q, count_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (cnt_en && (count_q != HOLD_MAX)) begin
      count_d = count_q + HOLD_W'(1);
    end
  end

  // Firing one count early lets the owner keep exactly MAX_HOLD contended cycles.
  assign expired = cnt_en && !clr && (count_q >= HOLD_LAST);

endmodule

// File: rtl/bus_arbiter_rr.sv
// Two-core bus arbiter: flush priority, then round-robin; forced release under ARB_TIMEOUT_EN.
// Request-to-grant 1 cycle; grants are registered and every handover inserts one idle cycle.
module bus_arbiter_rr
  import bus_arb_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic req_core1,
  input  logic req_core2,
  input  logic flush_in1,
  input  logic flush_in2,
  output logic grant_core1,
  output logic grant_core2,
  output logic bus_busy,
  output logic owner,
  output logic timeout_pulse
);

  arb_state_e state_q, state_d;
  logic       last_owner_q, last_owner_d;
  logic       owner_q, owner_d;
  logic       own_entry;
  logic       pick_vld;
  logic       pick;

  if ((MAX_HOLD < 2) || (MAX_HOLD > 255)) begin : g_max_hold_check
    $error("bus_arbiter_rr: MAX_HOLD must be within 2..255");
  end

`ifdef ARB_TIMEOUT_EN
  logic contended;
  logic hold_expired;
  logic timeout_q, timeout_d;

  assign contended = ((state_q == OWN1) && req_core2) || ((state_q == OWN2) && req_core1);

  arb_hold_timer #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (own_entry),
    .cnt_en  (contended),
    .expired (hold_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign timeout_pulse = timeout_q;
`else
  assign timeout_pulse = 1'b0;
`endif

  // Winner selection used only from IDLE.
  always_comb begin
    pick_vld = req_core1 | req_core2;
    pick     = ~last_owner_q;
    if (req_core1 && !req_core2) begin
      pick = OWNER_CORE1;
    end else if (req_core2 && !req_core1) begin
      pick = OWNER_CORE2;
    end else if (flush_in1 != flush_in2) begin
      pick = flush_in1 ? OWNER_CORE1 : OWNER_CORE2;
    end
`ifdef ARB_TIMEOUT_EN
    // A displaced owner cannot win straight back, even with flush raised.
    if (timeout_q && ((last_owner_q == OWNER_CORE1) ? req_core2 : req_core1)) begin
      pick = ~last_owner_q;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_owner_q <= OWNER_CORE2;
      owner_q      <= OWNER_CORE1;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
    end
  end

  always_comb begin
    state_d = state_q;
`ifdef ARB_TIMEOUT_EN
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = own_state(pick);
        end
      end
      OWN1: begin
        if (!req_core1) begin
          state_d = IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_expired && !flush_in1) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
`endif
      end
      OWN2: begin
        if (!req_core2) begin
          state_d = IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_expired && !flush_in2) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign own_entry = (state_q == IDLE) && (state_d != IDLE);

  always_comb begin
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    if (own_entry) begin
      last_owner_d = (state_d == OWN2) ? OWNER_CORE2 : OWNER_CORE1;
      owner_d      = last_owner_d;
    end
  end

  always_comb begin
    grant_core1 = (state_q == OWN1);
    grant_core2 = (state_q == OWN2);
    bus_busy    = (state_q != IDLE);
    owner       = owner_q;
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed and random checks of bus_arbiter_rr with MAX_HOLD=4; expectations follow ARB_TIMEOUT_EN.
module tb_bus_arbiter_rr;

  localparam int MH = 4;
`ifdef ARB_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic req_core1, req_core2, flush_in1, flush_in2;
  logic grant_core1, grant_core2, bus_busy, owner, timeout_pulse;

  int checks = 0;
  int errors = 0;

  bus_arbiter_rr #(
    .MAX_HOLD (MH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_core1     (req_core1),
    .req_core2     (req_core2),
    .flush_in1     (flush_in1),
    .flush_in2     (flush_in2),
    .grant_core1   (grant_core1),
    .grant_core2   (grant_core2),
    .bus_busy      (bus_busy),
    .owner         (owner),
    .timeout_pulse (timeout_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // grants packed as {grant_core2, grant_core1}
  task automatic chk_state(input string tag, input logic [1:0] g, input logic own, input logic to);
    chk({tag, "_grants"}, {6'd0, grant_core2, grant_core1}, {6'd0, g});
    chk({tag, "_busy"}, {7'd0, bus_busy}, {7'd0, |g});
    chk({tag, "_owner"}, {7'd0, owner}, {7'd0, own});
    chk({tag, "_timeout"}, {7'd0, timeout_pulse}, {7'd0, to});
  endtask

  task automatic drive(input logic r1, input logic r2, input logic f1, input logic f2);
    req_core1 = r1;
    req_core2 = r2;
    flush_in1 = f1;
    flush_in2 = f2;
  endtask

  logic pg1, pg2;
`ifdef ARB_TIMEOUT_EN
  int wait1, wait2;
`endif

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0);
    #3;
    chk_state("reset", 2'b00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Single request: 1-cycle latency, owner core1.
    drive(1, 0, 0, 0);
    tick();
    chk_state("single_req1", 2'b01, 1'b0, 1'b0);
    drive(0, 0, 0, 0);
    tick();
    chk_state("single_drop", 2'b00, 1'b0, 1'b0);

    // Fresh reset: both request, core1 wins first, turnaround before core2.
    reset = 1'b0;
    #1;
    reset = 1'b1;
    drive(1, 1, 0, 0);
    tick();
    chk_state("rr_first", 2'b01, 1'b0, 1'b0);
    tick();
    chk_state("rr_hold", 2'b01, 1'b0, 1'b0);
    drive(0, 1, 0, 0);
    tick();
    chk_state("rr_turnaround", 2'b00, 1'b0, 1'b0);
    tick();
    chk_state("rr_second", 2'b10, 1'b1, 1'b0);
    drive(0, 0, 0, 0);
    tick();
    chk_state("rr_release", 2'b00, 1'b1, 1'b0);

    // Flush priority vs round-robin; last owner is core2 here.
    drive(1, 1, 0, 1);
    tick();
    chk_state("flush2_wins", 2'b10, 1'b1, 1'b0);
    drive(0, 0, 0, 0);
    tick();
    drive(1, 1, 0, 0);
    tick();
    chk_state("rr_core1", 2'b01, 1'b0, 1'b0);
    drive(0, 0, 0, 0);
    tick();
    drive(1, 1, 1, 0);
    tick();
    chk_state("flush1_wins", 2'b01, 1'b0, 1'b0);
    drive(0, 0, 0, 0);
    tick();
    drive(1, 1, 1, 1);
    tick();
    chk_state("both_flush_rr", 2'b10, 1'b1, 1'b0);
    drive(0, 0, 0, 0);
    tick();

    // Core1 holds while core2 contends continuously.
    drive(1, 0, 0, 0);
    tick();
    chk_state("hold_own", 2'b01, 1'b0, 1'b0);
    drive(1, 1, 0, 0);
    for (int k = 0; k < MH - 1; k++) begin
      tick();
      chk_state("hold_contend", 2'b01, 1'b0, 1'b0);
    end
    tick();
    chk_state("hold_limit", TO_EN ? 2'b00 : 2'b01, 1'b0, TO_EN);
    tick();
    chk_state("hold_handover", TO_EN ? 2'b10 : 2'b01, TO_EN, 1'b0);
    drive(0, 0, 0, 0);
    tick();
    tick();
    chk_state("hold_idle", 2'b00, TO_EN, 1'b0);

    // Flushing owner is never forced off; release follows once flush drops.
    drive(1, 0, 1, 0);
    tick();
    chk_state("flush_own", 2'b01, 1'b0, 1'b0);
    drive(1, 1, 1, 0);
    for (int k = 0; k < MH + 2; k++) begin
      tick();
      chk_state("flush_exempt", 2'b01, 1'b0, 1'b0);
    end
    drive(1, 1, 0, 0);
    tick();
    chk_state("flush_dropped", TO_EN ? 2'b00 : 2'b01, 1'b0, TO_EN);
    drive(0, 0, 0, 0);
    tick();
    tick();

    // Asynchronous reset while core2 owns.
    drive(0, 1, 0, 0);
    tick();
    chk_state("pre_reset_own2", 2'b10, 1'b1, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk_state("async_reset", 2'b00, 1'b0, 1'b0);
    drive(0, 0, 0, 0);
    tick();
    reset = 1'b1;
    tick();
    chk_state("post_reset_idle1", 2'b00, 1'b0, 1'b0);
    tick();
    chk_state("post_reset_idle2", 2'b00, 1'b0, 1'b0);

    // Request held through reset is granted on the first edge with reset high.
    reset = 1'b0;
    drive(1, 0, 0, 0);
    tick();
    chk_state("req_in_reset", 2'b00, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    chk_state("first_arb", 2'b01, 1'b0, 1'b0);
    drive(0, 0, 0, 0);
    tick();

    // Random traffic: mutual exclusion, turnaround, starvation bound.
    pg1 = grant_core1;
    pg2 = grant_core2;
`ifdef ARB_TIMEOUT_EN
    wait1 = 0;
    wait2 = 0;
`endif
    for (int i = 0; i < 10000; i++) begin
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
            (i < 5000) && ($urandom_range(0, 3) == 0),
            (i < 5000) && ($urandom_range(0, 3) == 0));
      tick();
      chk("rnd_onehot", {7'd0, grant_core1 & grant_core2}, 8'd0);
      chk("rnd_no_swap", {7'd0, (pg1 & grant_core2) | (pg2 & grant_core1)}, 8'd0);
`ifdef ARB_TIMEOUT_EN
      if (i >= 5000) begin
        wait1 = (req_core1 && !grant_core1) ? wait1 + 1 : 0;
        wait2 = (req_core2 && !grant_core2) ? wait2 + 1 : 0;
        chk("rnd_starve1", {7'd0, wait1 > MH + 2}, 8'd0);
        chk("rnd_starve2", {7'd0, wait2 > MH + 2}, 8'd0);
      end
`else
      chk("rnd_no_timeout", {7'd0, timeout_pulse}, 8'd0);
`endif
      pg1 = grant_core1;
      pg2 = grant_core2;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_rr.md
BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 16, the maximum consecutive cycles one core may own the bus while the other requests (range 2..255).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have ports req_core1 and req_core2, input, 1 each, bus request from each core, level-held until the core finishes.
REQ-005 The block SHALL have ports flush_in1 and flush_in2, input, 1 each, which mark a pending request as a flush writeback with priority.
REQ-006 The block SHALL have ports grant_core1 and grant_core2, output, 1 each, registered one-hot-or-zero grants.
REQ-007 The block SHALL have port bus_busy, output, 1, high while any grant is asserted.
REQ-008 The block SHALL have port owner, output, 1, with 0=core1 and 1=core2, valid when bus_busy is high and otherwise holding the last owner.
REQ-009 The block SHALL have port timeout_pulse, output, 1, a one-cycle pulse on a forced release.

Function
REQ-010 The FSM SHALL have states IDLE, OWN1 and OWN2; grant_core1 SHALL be high only in OWN1 and grant_core2 only in OWN2.
REQ-011 In IDLE with exactly one req high, the FSM SHALL enter that core's OWN state on the next edge, giving 1-cycle request-to-grant latency.
REQ-012 In IDLE with both req high and exactly one matching flush high, the flushing core SHALL win.
REQ-013 In IDLE with both req high and both or neither flush high, the winner SHALL be the core that is not the last owner (round-robin); the last owner after reset is core2, so core1 wins first.
REQ-014 In OWNx, the grant SHALL hold while req_corex stays high; when req_corex drops, the FSM SHALL return to IDLE on the next edge.
REQ-015 There SHALL be no direct OWN1-to-OWN2 transfer; every handover SHALL pass through at least one IDLE cycle (bus turnaround).
REQ-016 The hold counter SHALL clear on OWN entry, increment each OWN cycle while the other core requests, and saturate at MAX_HOLD.
REQ-017 Requests arriving during OWN SHALL be evaluated only in IDLE, with no queuing beyond the req level.
REQ-018 The last owner SHALL update on every OWN entry.

Reset
REQ-019 While reset is low, the block SHALL hold state IDLE, both grants 0, bus_busy 0, owner 0, timeout_pulse 0, hold counter 0, and last owner core2.
REQ-020 Reset asserted mid-ownership SHALL drop the grant immediately (asynchronously); after release, the first arbitration SHALL occur on the first edge with reset high.

Configuration
REQ-021 With ARB_TIMEOUT_EN defined, when the hold counter reaches MAX_HOLD in OWNx with the other core still requesting, the FSM SHALL go to IDLE, pulse timeout_pulse for one cycle, and grant the other core next regardless of req_corex.
REQ-022 A flushing owner (flush_inx high) SHALL be exempt from forced release.
REQ-023 Without ARB_TIMEOUT_EN, the hold counter SHALL not exist, timeout_pulse SHALL be tied 0, and ownership SHALL end only when req drops.

Structure
REQ-024 Package bus_arb_pkg SHALL hold the state enum (IDLE, OWN1, OWN2), the owner encoding constants, and the MAX_HOLD default.
REQ-025 Sub-module arb_hold_timer (clear, count-enable, saturating count, expired flag) SHALL be instantiated only under ARB_TIMEOUT_EN.

Verification
REQ-026 Reset release, then req_core1=1 at cycle 0 -> grant_core1=1 at cycle 1, bus_busy=1, owner=0.
REQ-027 Both req high from IDLE right after reset, no flush -> core1 granted; after core1 drops req, one IDLE cycle, then core2 granted.
REQ-028 Both req high, flush_in2=1 only, last owner core2 -> core2 granted (flush beats round-robin).
REQ-029 ARB_TIMEOUT_EN, MAX_HOLD=4: core1 owns, core2 requests continuously, core1 never drops -> after 4 contended cycles, IDLE with timeout_pulse=1, then grant_core2=1; same test with flush_in1=1 -> no release.
REQ-030 reset asserted while grant_core2=1 -> grant drops with no clock edge; after release with no requests -> remains in IDLE.
REQ-031 Random req/flush traffic, 10k cycles -> grants never both high, no back-to-back owner swap without IDLE, no starvation beyond MAX_HOLD+2 cycles with ARB_TIMEOUT_EN.
